// File: rtl/lcm_stein.sv
// rtl/lcm_stein.sv - 8-bit LCM unit: Stein GCD, restoring divide, shift-add multiply
module lcm_stein (
    input  logic        clk,
    input  logic        clr,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    input  logic        go,
    output logic        busy,
    output logic        done,
    output logic [7:0]  gcd_out,
    output logic [15:0] lcm_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GCD,
        S_DIV,
        S_MUL,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [7:0]  r_ra;
    logic [7:0]  r_rb;
    logic [7:0]  r_x;
    logic [7:0]  r_y;
    logic [2:0]  r_k;
    logic [7:0]  r_g;
    logic        r_zero;
    logic [7:0]  r_rem;
    logic [7:0]  r_q;
    logic [3:0]  r_cnt;
    logic [15:0] r_acc;
    logic [15:0] r_mcand;
    logic [7:0]  r_mplier;
    logic [7:0]  r_gcd_out;
    logic [15:0] r_lcm_out;

    logic [8:0]  w_rem_shift;
    logic        w_fits;
    logic [7:0]  w_rem_sub;
    logic [15:0] w_acc_sum;

    // Partial remainder never exceeds the divisor, so the low byte of the
    // difference is exact whenever the divisor fits.
    assign w_rem_shift = {r_rem, r_q[7]};
    assign w_fits      = (w_rem_shift >= {1'b0, r_g});
    assign w_rem_sub   = w_rem_shift[7:0] - r_g;
    assign w_acc_sum   = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    // State register.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic. A zero operand spends its single GCD cycle only to
    // report the trivial result; divider and multiplier are skipped.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (go) w_next = S_GCD;
            S_GCD: begin
                if (r_zero)          w_next = S_DONE;
                else if (r_x == r_y) w_next = S_DIV;
            end
            S_DIV:  if (r_cnt == 4'd7) w_next = S_MUL;
            S_MUL:  if (r_cnt == 4'd8) w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: operand capture, GCD reduction, division, multiplication and
    // result registers (loaded on the edge entering DONE so they are valid
    // together with done).
    always_ff @(posedge clk) begin
        if (clr) begin
            r_ra      <= '0;
            r_rb      <= '0;
            r_x       <= '0;
            r_y       <= '0;
            r_k       <= '0;
            r_g       <= '0;
            r_zero    <= 1'b0;
            r_rem     <= '0;
            r_q       <= '0;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_gcd_out <= '0;
            r_lcm_out <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (go) begin
                        r_ra   <= a;
                        r_rb   <= b;
                        r_x    <= a;
                        r_y    <= b;
                        r_k    <= '0;
                        r_zero <= (a == 8'd0) || (b == 8'd0);
                        r_g    <= a | b;
                    end
                end
                S_GCD: begin
                    if (r_zero) begin
                        r_gcd_out <= r_g;
                        r_lcm_out <= '0;
                    end else if (r_x == r_y) begin
                        r_g   <= r_x << r_k;
                        r_rem <= '0;
                        r_q   <= r_ra;
                        r_cnt <= '0;
                    end else if (!r_x[0] && !r_y[0]) begin
                        r_x <= r_x >> 1;
                        r_y <= r_y >> 1;
                        r_k <= r_k + 3'd1;
                    end else if (!r_x[0]) begin
                        r_x <= r_x >> 1;
                    end else if (!r_y[0]) begin
                        r_y <= r_y >> 1;
                    end else if (r_x > r_y) begin
                        r_x <= (r_x - r_y) >> 1;
                    end else begin
                        r_y <= (r_y - r_x) >> 1;
                    end
                end
                S_DIV: begin
                    r_rem <= w_fits ? w_rem_sub : w_rem_shift[7:0];
                    r_q   <= {r_q[6:0], w_fits};
                    r_cnt <= (r_cnt == 4'd7) ? 4'd0 : r_cnt + 4'd1;
                end
                S_MUL: begin
                    // Step 0 loads the multiplier from the finished quotient;
                    // steps 1..8 each consume one multiplier bit.
                    if (r_cnt == 4'd0) begin
                        r_acc    <= '0;
                        r_mcand  <= {8'd0, r_rb};
                        r_mplier <= r_q;
                    end else begin
                        r_acc    <= w_acc_sum;
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        if (r_cnt == 4'd8) begin
                            r_gcd_out <= r_g;
                            r_lcm_out <= w_acc_sum;
                        end
                    end
                    r_cnt <= r_cnt + 4'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy    = (r_state != S_IDLE);
    assign done    = (r_state == S_DONE);
    assign gcd_out = r_gcd_out;
    assign lcm_out = r_lcm_out;

endmodule

// File: tb/tb_lcm_stein.sv
// tb/tb_lcm_stein.sv - scoreboard bench for lcm_stein with random and directed operands
module tb_lcm_stein;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic        go = 1'b0;
    logic        busy;
    logic        done;
    logic [7:0]  gcd_out;
    logic [15:0] lcm_out;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_g = 0;
    int last_l = 0;

    typedef struct {
        int g;
        int l;
        int acc;
        int lat;
    } exp_t;

    exp_t sb[$];

    lcm_stein dut (
        .clk(clk),
        .clr(clr),
        .a(a),
        .b(b),
        .go(go),
        .busy(busy),
        .done(done),
        .gcd_out(gcd_out),
        .lcm_out(lcm_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic int ref_gcd(input int x, input int y);
        int t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Number of GCD-state cycles: one per reduction rule applied, plus the
    // cycle that sees x == y.
    function automatic int ref_steps(input int x, input int y);
        int n = 0;
        forever begin
            n++;
            if (x == y) break;
            if (x % 2 == 0 && y % 2 == 0) begin x = x / 2; y = y / 2; end
            else if (x % 2 == 0) x = x / 2;
            else if (y % 2 == 0) y = y / 2;
            else if (x > y) x = (x - y) / 2;
            else y = (y - x) / 2;
        end
        return n;
    endfunction

    function automatic exp_t make_exp(input int ia, input int ib, input int acc);
        exp_t e;
        e.g   = ref_gcd(ia, ib);
        e.acc = acc;
        if (ia == 0 || ib == 0) begin
            e.l   = 0;
            e.lat = 1;
        end else begin
            e.l   = (ia * ib) / e.g;
            e.lat = ref_steps(ia, ib) + 17;
        end
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no request pending (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                chk("gcd_out", int'(gcd_out), e.g);
                chk("lcm_out", int'(lcm_out), e.l);
                chk("latency", cyc - e.acc, e.lat);
                chk("busy_with_done", int'(busy), 1);
            end
        end
    end

    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while (busy && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got busy=1 expected 0 within 100 cycles");
        end
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic push_exp(input int ia, input int ib);
        exp_t e;
        e = make_exp(ia, ib, cyc);
        sb.push_back(e);
        last_g = e.g;
        last_l = e.l;
    endtask

    task automatic run_op(input logic [7:0] ia, input logic [7:0] ib);
        wait_idle();
        chk("hold_gcd", int'(gcd_out), last_g);
        chk("hold_lcm", int'(lcm_out), last_l);
        a  = ia;
        b  = ib;
        go = 1'b1;
        @(posedge clk);
        #1;
        push_exp(int'(ia), int'(ib));
        @(negedge clk);
        go = 1'b0;
        a  = 8'($urandom_range(0, 255));
        b  = 8'($urandom_range(0, 255));
        drain();
    endtask

    // go stays high across the whole operation while the operands move;
    // the second request is accepted in the IDLE cycle after done.
    task automatic run_b2b(input logic [7:0] a1, input logic [7:0] b1,
                           input logic [7:0] a2, input logic [7:0] b2);
        wait_idle();
        a  = a1;
        b  = b1;
        go = 1'b1;
        @(posedge clk);
        #1;
        push_exp(int'(a1), int'(b1));
        @(negedge clk);
        a = a2;
        b = b2;
        drain();
        @(posedge clk);
        @(posedge clk);
        #1;
        push_exp(int'(a2), int'(b2));
        @(negedge clk);
        go = 1'b0;
        drain();
    endtask

    task automatic run_clr_in_div(input logic [7:0] ia, input logic [7:0] ib);
        int n;
        wait_idle();
        n  = ref_steps(int'(ia), int'(ib));
        a  = ia;
        b  = ib;
        go = 1'b1;
        @(posedge clk);
        #1;
        push_exp(int'(ia), int'(ib));
        go = 1'b0;
        repeat (n + 3) @(posedge clk);
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        void'(sb.pop_back());
        @(negedge clk);
        clr = 1'b0;
        chk("clr_gcd_out", int'(gcd_out), 0);
        chk("clr_lcm_out", int'(lcm_out), 0);
        chk("clr_busy", int'(busy), 0);
        chk("clr_done", int'(done), 0);
        last_g = 0;
        last_l = 0;
        repeat (40) @(posedge clk);
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;

        clr = 1'b1;
        go  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        chk("reset_gcd_out", int'(gcd_out), 0);
        chk("reset_lcm_out", int'(lcm_out), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        repeat (5) @(posedge clk);

        run_op(8'd9, 8'd24);
        run_op(8'd12, 8'd12);
        run_op(8'd255, 8'd254);
        run_op(8'd128, 8'd96);
        run_op(8'd0, 8'd5);
        run_op(8'd0, 8'd0);
        run_op(8'd7, 8'd0);
        run_op(8'd1, 8'd1);
        run_op(8'd255, 8'd255);
        run_op(8'd1, 8'd255);
        run_op(8'd128, 8'd1);

        run_b2b(8'd9, 8'd24, 8'd100, 8'd75);
        run_b2b(8'd200, 8'd3, 8'd0, 8'd9);

        run_clr_in_div(8'd200, 8'd150);

        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) ra = 8'd0;
            if ($urandom_range(0, 7) == 0) rb = 8'd0;
            run_op(ra, rb);
        end

        repeat (5) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
